// File: rtl/seg7_scan_ctrl.sv
// Time-multiplexed scan controller for a common-anode 7-segment display.
// Drives one shared decoder per digit slot; display value is double-buffered to frame boundaries.
module seg7_scan_ctrl #(
  parameter int NDIG     = 4,
  parameter int ON_CYC   = 1000,
  parameter int DEAD_CYC = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [4*NDIG-1:0] value,
  input  logic              load,
  input  logic              lzb_en,
  output logic [3:0]        hex,
  output logic              erase,
  output logic [NDIG-1:0]   an,
  output logic              pending,
  output logic              frame_tick
);

  localparam int MAXP = (ON_CYC > DEAD_CYC) ? ON_CYC : DEAD_CYC;
  localparam int CW   = (MAXP > 1) ? $clog2(MAXP) : 1;
  localparam int IW   = $clog2(NDIG);

  localparam logic [CW-1:0] ON_LAST   = CW'(ON_CYC - 1);
  localparam logic [CW-1:0] DEAD_LAST = (DEAD_CYC > 0) ? CW'(DEAD_CYC - 1) : '0;
  localparam logic [IW-1:0] IDX_LAST  = IW'(NDIG - 1);

  typedef enum logic [1:0] {ST_START, ST_ON, ST_DEAD} state_t;

  state_t              state_q, state_d;
  logic [IW-1:0]       idx_q, idx_d, idx_nxt;
  logic [CW-1:0]       cnt_q, cnt_d;
  logic [4*NDIG-1:0]   stage_q, stage_d;
  logic [4*NDIG-1:0]   disp_q, disp_d;
  logic                pending_q, pending_d;
  logic                tick_q, tick_d;
  logic [NDIG-1:0]     an_q, an_d;
  logic [3:0]          hex_q, hex_d;
  logic                erase_q, erase_d;
  logic                boundary;
  logic [NDIG-1:0]     blank;
  logic                upper_zero;
  logic [NDIG-1:0]     an_sel;
  logic [3:0]          hex_sel;
  logic                blank_sel;

  assign idx_nxt = (idx_q == IDX_LAST) ? '0 : idx_q + IW'(1);

  always_comb begin
    state_d  = state_q;
    idx_d    = idx_q;
    cnt_d    = cnt_q;
    boundary = 1'b0;
    case (state_q)
      ST_START: begin
        state_d  = ST_ON;
        idx_d    = '0;
        cnt_d    = '0;
        boundary = 1'b1;
      end
      ST_ON: begin
        if (cnt_q == ON_LAST) begin
          cnt_d = '0;
          if (DEAD_CYC > 0) begin
            state_d = ST_DEAD;
          end else begin
            idx_d    = idx_nxt;
            boundary = (idx_q == IDX_LAST);
          end
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      ST_DEAD: begin
        if (cnt_q == DEAD_LAST) begin
          cnt_d    = '0;
          state_d  = ST_ON;
          idx_d    = idx_nxt;
          boundary = (idx_q == IDX_LAST);
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      default: state_d = ST_START;
    endcase
  end

  // A load on the boundary cycle lands in stage while disp takes the old stage.
  always_comb begin
    stage_d   = load ? value : stage_q;
    disp_d    = (boundary && pending_q) ? stage_q : disp_q;
    tick_d    = boundary && pending_q;
    pending_d = pending_q;
    if (load) begin
      pending_d = 1'b1;
    end else if (boundary) begin
      pending_d = 1'b0;
    end
  end

  // Scan from the top nibble down, tracking whether everything above is zero.
  always_comb begin
    blank      = '0;
    upper_zero = 1'b1;
    for (int unsigned j = 0; j < NDIG; j++) begin
      int unsigned i;
      i          = NDIG - 1 - j;
      upper_zero = upper_zero & (disp_q[4*i +: 4] == 4'h0);
      if (i != 0) begin
        blank[i] = lzb_en & upper_zero;
      end
    end
  end

  always_comb begin
    an_sel    = '1;
    hex_sel   = '0;
    blank_sel = 1'b0;
    for (int unsigned j = 0; j < NDIG; j++) begin
      if (idx_q == IW'(j)) begin
        an_sel[j] = 1'b0;
        hex_sel   = disp_q[4*j +: 4];
        blank_sel = blank[j];
      end
    end
  end

  always_comb begin
    an_d    = '1;
    hex_d   = '0;
    erase_d = 1'b1;
    if (state_q == ST_ON) begin
      an_d    = an_sel;
      hex_d   = hex_sel;
      erase_d = blank_sel;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= ST_START;
      idx_q     <= '0;
      cnt_q     <= '0;
      stage_q   <= '0;
      disp_q    <= '0;
      pending_q <= 1'b0;
      tick_q    <= 1'b0;
      an_q      <= '1;
      hex_q     <= '0;
      erase_q   <= 1'b1;
    end else begin
      state_q   <= state_d;
      idx_q     <= idx_d;
      cnt_q     <= cnt_d;
      stage_q   <= stage_d;
      disp_q    <= disp_d;
      pending_q <= pending_d;
      tick_q    <= tick_d;
      an_q      <= an_d;
      hex_q     <= hex_d;
      erase_q   <= erase_d;
    end
  end

  assign an         = an_q;
  assign hex        = hex_q;
  assign erase      = erase_q;
  assign pending    = pending_q;
  assign frame_tick = tick_q;

endmodule

// File: tb/tb_seg7_scan_ctrl.sv
// Directed bench for seg7_scan_ctrl: NDIG=4, ON_CYC=4, DEAD_CYC=2, plus a DEAD_CYC=0 instance.
module tb_seg7_scan_ctrl;

  logic        clk;
  logic        rst;
  logic [15:0] value;
  logic        load;
  logic        lzb_en;
  logic [3:0]  hex,  hex0;
  logic        erase, erase0;
  logic [3:0]  an,   an0;
  logic        pending, pending0;
  logic        frame_tick, frame_tick0;

  int total = 0;
  int bad   = 0;

  seg7_scan_ctrl #(.NDIG(4), .ON_CYC(4), .DEAD_CYC(2)) dut (
    .clk(clk), .rst(rst), .value(value), .load(load), .lzb_en(lzb_en),
    .hex(hex), .erase(erase), .an(an), .pending(pending), .frame_tick(frame_tick)
  );

  seg7_scan_ctrl #(.NDIG(4), .ON_CYC(4), .DEAD_CYC(0)) dut0 (
    .clk(clk), .rst(rst), .value(value), .load(load), .lzb_en(lzb_en),
    .hex(hex0), .erase(erase0), .an(an0), .pending(pending0), .frame_tick(frame_tick0)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    assert (got === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, got, exp);
    end
  endtask

  // Entered just after a boundary edge; runs 24 cycles, ending just after the next boundary.
  // hx/er give per-digit expected nibble and erase; loads are applied on the edge of cycle la/lb.
  task automatic check_frame(input string tag, input logic [15:0] hx, input logic [3:0] er,
                             input int la, input logic [15:0] lva,
                             input int lb, input logic [15:0] lvb);
    logic [8:0] e;
    int p, d;
    for (int k = 1; k <= 24; k++) begin
      if (k == la) begin
        load = 1'b1; value = lva;
      end else if (k == lb) begin
        load = 1'b1; value = lvb;
      end
      tick();
      load = 1'b0;
      p = k - 1;
      d = p / 6;
      if ((p % 6) < 4) e = {4'hF ^ (4'h1 << d), hx[4*d +: 4], er[d]};
      else             e = {4'hF, 4'h0, 1'b1};
      chk(tag, 32'({an, hex, erase}), 32'(e));
      if (k < 24) chk({tag, "_tick"}, 32'(frame_tick), 32'd0);
    end
  endtask

  initial begin
    rst = 1'b1; load = 1'b0; value = '0; lzb_en = 1'b0;
    repeat (2) tick();
    chk("rst_out",  32'({an, hex, erase}), 32'({4'hF, 4'h0, 1'b1}));
    chk("rst_pend", 32'({pending, frame_tick}), 32'd0);
    chk("rst_out0", 32'({an0, hex0, erase0, pending0, frame_tick0}), 32'({4'hF, 4'h0, 1'b1, 2'b00}));

    // Test 1: load during START lands in stage; first frame shows 0
    rst = 1'b0; load = 1'b1; value = 16'h12AF;
    tick();
    load = 1'b0;
    chk("start_out", 32'({an, erase}), 32'({4'hF, 1'b1}));
    chk("start_pend", 32'({pending, frame_tick}), 32'({1'b1, 1'b0}));
    check_frame("f1", 16'h0000, 4'b0000, -1, '0, -1, '0);
    chk("f1_end", 32'({frame_tick, pending}), 32'({1'b1, 1'b0}));

    // Test 2: leading-zero blanking
    lzb_en = 1'b1;
    check_frame("f2", 16'h12AF, 4'b0000, 3, 16'h0050, -1, '0);
    chk("f2_end", 32'({frame_tick, pending}), 32'({1'b1, 1'b0}));
    check_frame("f3", 16'h0050, 4'b1100, 5, 16'h0000, -1, '0);
    chk("f3_end", 32'({frame_tick, pending}), 32'({1'b1, 1'b0}));

    // Test 3: two loads in one frame, last wins
    check_frame("f4", 16'h0000, 4'b1110, 6, 16'h1111, 14, 16'h2222);
    chk("f4_end", 32'({frame_tick, pending}), 32'({1'b1, 1'b0}));
    lzb_en = 1'b0;

    // Test 4: load on the boundary edge keeps pending set
    check_frame("f5", 16'h2222, 4'b0000, 8, 16'h7777, 24, 16'h3333);
    chk("f5_end", 32'({frame_tick, pending}), 32'({1'b1, 1'b1}));
    check_frame("f6", 16'h7777, 4'b0000, -1, '0, -1, '0);
    chk("f6_end", 32'({frame_tick, pending}), 32'({1'b1, 1'b0}));

    // Test 5: async reset during ON(2)
    load = 1'b1; value = 16'h9999;
    tick();
    load = 1'b0;
    repeat (13) tick();
    chk("on2_out",  32'({an, hex, erase}), 32'({4'b1011, 4'h3, 1'b0}));
    chk("on2_pend", 32'(pending), 32'd1);
    #2 rst = 1'b1;
    #1;
    chk("arst_out",  32'({an, hex, erase}), 32'({4'hF, 4'h0, 1'b1}));
    chk("arst_pend", 32'({pending, frame_tick}), 32'd0);
    repeat (2) tick();
    chk("arst_hold", 32'({an, hex, erase, pending}), 32'({4'hF, 4'h0, 1'b1, 1'b0}));
    rst = 1'b0;
    tick();
    chk("restart_out",  32'({an, erase}), 32'({4'hF, 1'b1}));
    chk("restart_out0", 32'({an0, erase0}), 32'({4'hF, 1'b1}));

    // Test 6: DEAD_CYC=0 instance never blanks all digits; 16-cycle frame
    for (int k = 1; k <= 32; k++) begin
      int d;
      logic [15:0] v0;
      if (k == 3) begin
        load = 1'b1; value = 16'hABCD;
      end
      tick();
      load = 1'b0;
      d  = ((k - 1) / 4) % 4;
      v0 = (k >= 17) ? 16'hABCD : 16'h0000;
      chk("nodead_out", 32'({an0, hex0, erase0}), 32'({4'hF ^ (4'h1 << d), v0[4*d +: 4], 1'b0}));
      chk("nodead_tick", 32'(frame_tick0), 32'(k == 16));
      if (k == 1) chk("restart_on0", 32'({an, hex, erase}), 32'({4'b1110, 4'h0, 1'b0}));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
